// File: rtl/mdr_pkg.sv
// Shared types and helpers for the memory data register unit.
// Holds the size encodings, FSM state encoding and the request legality check.
package mdr_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_DBL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StWait    = 2'b01,
        StRelease = 2'b10
    } state_e;

    // addr carries only the address bits that matter for the current data width.
    function automatic logic misaligned(size_e sz, logic [2:0] addr, logic wide);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = !wide || (addr != 3'b000);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Big-endian lane steering: store replication with byte enables, and load
// field extraction with sign or zero extension.
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB = DATA_W / 8,
    localparam int unsigned AW = $clog2(DATA_W / 8)
) (
    input  size_e             size,
    input  logic              signed_ld,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] ds,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] ldata
);

    logic [NB-1:0]     fmask;
    logic [DATA_W-1:0] up;
    int unsigned       nbytes;
    int unsigned       sh;

    always_comb begin
        wdata  = ds;
        fmask  = '1;
        nbytes = NB;
        sh     = 0;
        case (size)
            SZ_BYTE: begin
                wdata  = {NB{ds[7:0]}};
                fmask  = NB'(1);
                nbytes = 1;
                sh     = DATA_W - 8;
            end
            SZ_HALF: begin
                wdata  = {(NB / 2){ds[15:0]}};
                fmask  = NB'(3);
                nbytes = 2;
                sh     = DATA_W - 16;
            end
            SZ_WORD: begin
                wdata  = {(NB / 4){ds[31:0]}};
                fmask  = NB'(4'hF);
                nbytes = 4;
                sh     = DATA_W - 32;
            end
            default: ;
        endcase
        // Enable bit NB-1-n belongs to address n, so the field sits that far from the top.
        be = fmask << (NB - nbytes - 32'(addr));

        // Put the addressed field at the top, then shift it down to extend.
        up = rdata << {addr, 3'b000};
        if (signed_ld) begin
            ldata = $signed(up) >>> sh;
        end else begin
            ldata = up >> sh;
        end
    end

endmodule

// File: rtl/mdr_unit.sv
// Memory data register with MOC/MFC handshake, timeout and request checking.
// All outputs are registered; lane steering is delegated to mdr_lane_align.
module mdr_unit
    import mdr_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_req,
    input  logic                st_req,
    input  logic [1:0]          size,
    input  logic                signed_ld,
    input  logic [2:0]          addr_lo,
    input  logic [DATA_W-1:0]   Ds,
    input  logic [DATA_W-1:0]   ram_dout,
    input  logic                ram_mfc,
    output logic                ram_moc,
    output logic                ram_rw,
    output logic [DATA_W-1:0]   ram_din,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [DATA_W-1:0]   mdr_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned AW = $clog2(NB);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic        WIDE = (DATA_W == 64);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    size_e             size_q;
    logic              sgn_q;
    logic [AW-1:0]     addr_q;

    logic [2:0]        addr_chk;
    logic              any_req;
    logic              illegal;
    size_e             al_size;
    logic              al_sgn;
    logic [AW-1:0]     al_addr;
    logic [DATA_W-1:0] al_wdata;
    logic [NB-1:0]     al_be;
    logic [DATA_W-1:0] al_ldata;

    always_comb begin
        addr_chk = addr_lo & (WIDE ? 3'b111 : 3'b011);
        any_req  = ld_req | st_req;
        illegal  = (ld_req & st_req) | misaligned(size_e'(size), addr_chk, WIDE);
        // Alignment uses live inputs in IDLE; extraction uses the latched request.
        if (state_q == StIdle) begin
            al_size = size_e'(size);
            al_sgn  = signed_ld;
            al_addr = addr_lo[AW-1:0];
        end else begin
            al_size = size_q;
            al_sgn  = sgn_q;
            al_addr = addr_q;
        end
    end

    mdr_lane_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .size     (al_size),
        .signed_ld(al_sgn),
        .addr     (al_addr),
        .ds       (Ds),
        .rdata    (ram_dout),
        .wdata    (al_wdata),
        .be       (al_be),
        .ldata    (al_ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            ram_moc <= 1'b0;
            ram_rw  <= 1'b0;
            ram_din <= '0;
            ram_be  <= '0;
            mdr_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req && illegal) begin
                        err <= 1'b1;
                    end else if (any_req) begin
                        size_q  <= size_e'(size);
                        sgn_q   <= signed_ld;
                        addr_q  <= addr_lo[AW-1:0];
                        if (st_req) begin
                            ram_din <= al_wdata;
                            ram_be  <= al_be;
                        end
                        ram_moc <= 1'b1;
                        ram_rw  <= ld_req;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (ram_mfc) begin
                        if (ram_rw) begin
                            mdr_out <= al_ldata;
                        end
                        ram_moc <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StRelease;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        ram_moc <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (!ram_mfc) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
